// File: rtl/tt_um_chandrakanth_serial_adder.sv
// Bit-serial 8-bit adder.
// Operands are loaded into A/B from ui_in. A start copies them into shift
// registers. One full-adder cell plus a carry flop then walks the bits
// LSB-first over 8 cycles. The result, carry-out and signed overflow are
// published only on the final RUN edge, so the outputs keep the previous
// result for the whole run.
module tt_um_chandrakanth_serial_adder (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  logic              load_a, load_b, start, cin;
  logic              any_load, start_go;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic [DATA_W-1:0] a_sh, b_sh, sum_sh;
  logic              carry;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] result;
  logic              cout_r, ovf_r;
  logic              bit_s, bit_c;
  logic              unused_ok;

  // Sum output of the single full-adder cell.
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Carry output of the single full-adder cell.
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

  assign load_a   = uio_in[0];
  assign load_b   = uio_in[1];
  assign start    = uio_in[2];
  assign cin      = uio_in[3];
  assign any_load = load_a | load_b;
  // A load in the same cycle wins over start.
  assign start_go = start & ~any_load;

  assign bit_s = fa_sum(a_sh[0], b_sh[0], carry);
  assign bit_c = fa_carry(a_sh[0], b_sh[0], carry);

  assign uo_out    = result;
  assign uio_out   = {ovf_r, (state == DONE), (state == RUN), cout_r, 4'b0000};
  assign uio_oe    = 8'hF0;
  assign unused_ok = &{1'b0, ena, uio_in[7:4]};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic. Loads and start are ignored while RUN is in progress.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_go) state_nx = RUN;
      RUN:     if (cnt == 3'd7) state_nx = DONE;
      DONE: begin
        if (any_load)      state_nx = IDLE;
        else if (start_go) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand loading, the serial add step, and publishing of the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (any_load) begin
            if (load_a) a_reg <= ui_in;
            if (load_b) b_reg <= ui_in;
          end else if (start) begin
            a_sh   <= a_reg;
            b_sh   <= b_reg;
            sum_sh <= '0;
            carry  <= cin;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= {bit_s, sum_sh[DATA_W-1:1]};
          carry  <= bit_c;
          // The count wraps 7->0 on the last bit, which is also the RUN->DONE edge.
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            result <= {bit_s, sum_sh[DATA_W-1:1]};
            cout_r <= bit_c;
            // At this point, carry is the carry into bit 7 and bit_c is the carry out of it.
            ovf_r  <= carry ^ bit_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/tt_um_chandrakanth_serial_adder.md
TT_UM_CHANDRAKANTH_SERIAL_ADDER -- requirements
Module: tt_um_chandrakanth_serial_adder

Interface
REQ-001 Parameter: none; operand width is fixed at 8 bits and the sequence length at 8 cycles.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ena  input  1  always 1 when powered; ignored.
REQ-005 ui_in  input  8  operand data bus, sampled by load_a/load_b.
REQ-006 uio_in  input  8  [0]=load_a, [1]=load_b, [2]=start, [3]=cin; [7:4] ignored.
REQ-007 uo_out  output  8  result register sum[7:0].
REQ-008 uio_out  output  8  [4]=cout, [5]=busy, [6]=done, [7]=ovf; [3:0] driven 0.
REQ-009 uio_oe  output  8  constant 8'hF0.

Function
REQ-010 Block SHALL hold operand registers A[7:0] and B[7:0], and SHALL compute A+B+cin bit-serially through one 1-bit full-adder cell plus a carry flip-flop.
REQ-011 FSM states SHALL be IDLE, RUN and DONE; busy=1 only in RUN; done=1 only in DONE.
REQ-012 In IDLE or DONE, load_a=1 SHALL load A<=ui_in and load_b=1 SHALL load B<=ui_in; when both are high, both SHALL load the same value.
REQ-013 In IDLE or DONE, start=1 with load_a=0 and load_b=0 SHALL, at that edge, copy A/B into shift registers, set carry<=cin, clear the bit counter and enter RUN.
REQ-014 When start and any load are asserted in the same cycle, the load SHALL take effect and start SHALL be ignored.
REQ-015 In RUN, each edge SHALL process one bit LSB-first: s=a0^b0^c, c<=(a0&b0)|(c&(a0^b0)), shift s into the partial-sum register from the MSB, shift A/B copies right, and increment the 3-bit counter.
REQ-016 On the 8th RUN edge (counter=7), the FSM SHALL transfer the partial sum to the result register, set cout to the final carry, set ovf to (carry into bit 7) XOR (carry out of bit 7), and enter DONE.
REQ-017 Latency: with start sampled at edge E0, done and the new result SHALL be visible after edge E8 (8 RUN cycles).
REQ-018 uo_out, cout and ovf SHALL hold the previous result throughout RUN and change only at the RUN->DONE edge.
REQ-019 load_a, load_b, start and cin SHALL be ignored in RUN, and A/B SHALL be unchanged by RUN.
REQ-020 DONE SHALL persist until start (-> RUN) or any load (-> IDLE, with the result retained).
REQ-021 Counter wrap: the counter SHALL wrap 7->0 only on the RUN->DONE edge and SHALL never run past 8 bits.

Reset
REQ-022 While rst_n=0 at a clock edge, state<=IDLE and A, B, shift registers, carry, counter, result, cout and ovf SHALL all be cleared to 0.
REQ-023 Reset asserted mid-RUN SHALL abort the operation: the next cycle shows uo_out=0, busy=0, done=0, and no stale result is ever presented.
REQ-024 uio_oe=8'hF0 and uio_out[3:0]=0 SHALL hold during and after reset.

Verification
REQ-025 A=0x5A, B=0x3C, cin=0, start -> busy for 8 cycles, then done=1, uo_out=0x96, cout=0, ovf=1.
REQ-026 A=0xFF, B=0x01, cin=0 -> uo_out=0x00, cout=1, ovf=0; A=0xFF, B=0xFF, cin=1 -> uo_out=0xFF, cout=1, ovf=0.
REQ-027 A=0x7F, B=0x00, cin=1 -> uo_out=0x80, cout=0, ovf=1; done exactly 8 edges after the start edge.
REQ-028 During RUN, pulse load_a (ui_in=0x11), start and cin -> no effect; result matches the original operands, and A reads back unchanged on the next op.
REQ-029 Start asserted with load_b in the same cycle -> B loaded, FSM stays IDLE, busy=0.
REQ-030 rst_n=0 at the 4th RUN cycle -> next cycle all outputs 0 and state IDLE; a fresh op afterwards yields the correct sum.
